// File: rtl/router_pkg.sv
// Shared types, constants and small decode helpers for the 1x3 router control block.
package router_pkg;

    localparam int NUM_PORTS       = 3;
    localparam int DEFAULT_TIMEOUT = 30;

    typedef logic [1:0] port_addr_t;

    localparam port_addr_t ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_t;

    // Selecting by address 3 yields 0 so an invalid destination never matches a port.
    function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec, input port_addr_t addr);
        logic bit_val;
        bit_val = 1'b0;
        case (addr)
            2'd0:    bit_val = vec[0];
            2'd1:    bit_val = vec[1];
            2'd2:    bit_val = vec[2];
            default: bit_val = 1'b0;
        endcase
        return bit_val;
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_addr_t addr);
        logic [NUM_PORTS-1:0] sel;
        sel = '0;
        case (addr)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_if.sv
// Handshake bundle between the router controller and its source, register block and FIFOs.
interface router_if;
    import router_pkg::*;

    logic                 pkt_valid;
    logic [1:0]           data_in;
    logic                 parity_done;
    logic                 low_packet_valid;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] read_enb;

    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 busy;
    logic                 fifo_full_sel;
    logic [NUM_PORTS-1:0] write_enb;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;

    modport master (
        output pkt_valid, data_in, parity_done, low_packet_valid,
               fifo_full, fifo_empty, read_enb,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, busy, fifo_full_sel, write_enb, vld_out, soft_reset
    );

    modport slave (
        input  pkt_valid, data_in, parity_done, low_packet_valid,
               fifo_full, fifo_empty, read_enb,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, busy, fifo_full_sel, write_enb, vld_out, soft_reset
    );

endinterface

// File: rtl/router_port_timer.sv
// Per-port read timeout: pulses soft_reset when valid data sits unread for TIMEOUT cycles.
module router_port_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    localparam logic [7:0] TERMINAL = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // A read on the terminal cycle clears the counter first, so no pulse is issued.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count      <= 8'd0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (!vld || read_enb) begin
                count <= 8'd0;
            end else if (count == TERMINAL) begin
                count      <= 8'd0;
                soft_reset <= 1'b1;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Packet FSM, destination latch, write steering and per-port timeouts for the 1x3 router.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic     clock,
    input  logic     resetn,
    router_if.slave  bus
);

    state_t     state;
    state_t     next_state;
    port_addr_t addr;
    logic       write_enb_int;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr <= 2'b00;
        end else if (bus.detect_add && bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
            addr <= bus.data_in;
        end
    end

    assign bus.fifo_full_sel = port_bit(bus.fifo_full, addr);
    assign bus.vld_out       = ~bus.fifo_empty;

    always_comb begin
        next_state = state;
        unique case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
                    next_state = port_bit(bus.fifo_empty, bus.data_in) ? LOAD_FIRST_DATA
                                                                       : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full_sel) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full_sel) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (bus.low_packet_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = bus.fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (port_bit(bus.fifo_empty, addr)) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        // A timeout on the port being written abandons the packet from any state.
        if (state != DECODE_ADDRESS && port_bit(bus.soft_reset, addr)) begin
            next_state = DECODE_ADDRESS;
        end
    end

    assign bus.detect_add  = (state == DECODE_ADDRESS);
    assign bus.lfd_state   = (state == LOAD_FIRST_DATA);
    assign bus.ld_state    = (state == LOAD_DATA);
    assign bus.laf_state   = (state == LOAD_AFTER_FULL);
    assign bus.full_state  = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg = (state == CHECK_PARITY_ERROR);
    assign bus.busy        = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

    assign write_enb_int = bus.ld_state || bus.laf_state || (state == LOAD_PARITY);
    assign bus.write_enb = write_enb_int ? port_onehot(addr) : 3'b000;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
        router_port_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (bus.vld_out[i]),
            .read_enb   (bus.read_enb[i]),
            .soft_reset (bus.soft_reset[i])
        );
    end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
Control block for the 1x3 router: a packet FSM plus destination sync logic.
- The FSM sequences the register/parity datapath through detect_add, lfd_state, ld_state, laf_state, full_state and rst_int_reg.
- It latches the 2-bit destination from the header and steers write enables to one of three output FIFOs.
- It drives busy back to the source and generates per-port valid and soft-reset (read timeout) signals.
- It sits between the input source, the register/parity block and the three output FIFOs.

Parameters:
TIMEOUT, 30, cycles a port may hold valid data unread before soft_reset pulses (legal range 2..255).
NUM_PORTS, 3, number of output FIFOs; fixed at 3 (address 2'b11 is invalid).

Ports:
clock  input  1  system clock, rising edge.
resetn  input  1  synchronous, active-low reset.
pkt_valid  input  1  source packet valid.
data_in  input  2  data_in[1:0] of the input byte; header destination field.
parity_done  input  1  from register block: parity byte captured.
low_packet_valid  input  1  from register block: pkt_valid fell during load.
fifo_full  input  3  per-port FIFO full.
fifo_empty  input  3  per-port FIFO empty.
read_enb  input  3  per-port reader read enable.
detect_add  output  1  FSM in DECODE_ADDRESS.
lfd_state  output  1  FSM in LOAD_FIRST_DATA.
ld_state  output  1  FSM in LOAD_DATA.
laf_state  output  1  FSM in LOAD_AFTER_FULL.
full_state  output  1  FSM in FIFO_FULL_STATE.
rst_int_reg  output  1  FSM in CHECK_PARITY_ERROR.
busy  output  1  source must hold data.
fifo_full_sel  output  1  fifo_full of latched destination.
write_enb  output  3  one-hot FIFO write enable.
vld_out  output  3  per-port data available (~fifo_empty).
soft_reset  output  3  per-port one-cycle timeout pulse.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state := DECODE_ADDRESS.
  - Latched address := 0.
  - Timers := 0, soft_reset := 0.
  - Outputs decode from state, so after reset detect_add=1 and all other state outputs, busy and write_enb are 0.
- State outputs: all are Moore, decoded from state.
- Address latch: updated with data_in when detect_add & pkt_valid & data_in!=3; otherwise held.
- fifo_full_sel: combinational mux of fifo_full by latched address.
- FSM transitions:
  - DECODE_ADDRESS:
    - pkt_valid & data_in=a (a<3) & fifo_empty[a] -> LOAD_FIRST_DATA.
    - pkt_valid & a<3 & ~fifo_empty[a] -> WAIT_TILL_EMPTY.
    - Otherwise, including a==3, stay.
  - LOAD_FIRST_DATA: always -> LOAD_DATA.
  - LOAD_DATA:
    - fifo_full_sel -> FIFO_FULL_STATE.
    - Else ~pkt_valid -> LOAD_PARITY.
    - Else stay.
  - FIFO_FULL_STATE: ~fifo_full_sel -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - Else low_packet_valid -> LOAD_PARITY.
    - Else -> LOAD_DATA.
  - LOAD_PARITY: always -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full_sel -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[latched] -> LOAD_FIRST_DATA, else stay.
- Soft-reset override: soft_reset[latched]=1 in any state other than DECODE_ADDRESS forces next state DECODE_ADDRESS. It takes priority over every other transition.
- busy = 1 in LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY and CHECK_PARITY_ERROR; 0 in DECODE_ADDRESS and LOAD_DATA.
- write_enb:
  - write_enb_int = ld_state | laf_state | (state==LOAD_PARITY).
  - write_enb = write_enb_int ? one-hot(latched address) : 3'b000.
  - write_enb is never asserted for address 3.
- vld_out[i] = ~fifo_empty[i] (combinational).
- Timer, per port i, 8-bit counter:
  - Clears to 0 when ~vld_out[i] or read_enb[i].
  - Otherwise increments.
  - When the counter equals TIMEOUT-1 while counting: soft_reset[i] <= 1 for exactly one cycle and the counter returns to 0.
  - soft_reset is registered, so the pulse appears TIMEOUT cycles after the first unread-valid cycle.
  - read_enb in the same cycle as the terminal count suppresses the pulse.
- Simultaneous events:
  - Soft reset of a non-latched port has no effect on the FSM.
  - fifo_full_sel and ~pkt_valid together in LOAD_DATA: full wins.

Decomposition:
- Shared package router_pkg:
  - typedef enum logic [2:0] state_t with the 8 states above.
  - typedef logic [1:0] port_addr_t.
  - Localparam ADDR_INVALID=2'b11.
  - Default TIMEOUT.
- Sub-module router_port_timer, instantiated 3 times:
  - Inputs: clock, resetn, vld, read_enb.
  - Output: soft_reset.
  - Parameter TIMEOUT.

Test Plan:
- Header 8'h01 with pkt_valid, fifo_empty=3'b111 -> next cycle lfd_state=1, busy=1. Then ld_state=1 and write_enb=3'b010 during the payload. pkt_valid=0 -> LOAD_PARITY with write_enb=3'b010, then rst_int_reg=1 for 1 cycle, then detect_add=1.
- Header 8'h02 with fifo_empty[2]=0 -> WAIT_TILL_EMPTY, busy=1, write_enb=0. fifo_empty[2]=1 -> LOAD_FIRST_DATA next cycle.
- Address 0 packet with fifo_full[0]=1 mid-payload -> full_state=1, write_enb=0. Full released with low_packet_valid=0 -> laf_state for 1 cycle, then ld_state. Repeat with parity_done=1 -> laf_state then detect_add.
- Header address 3 with pkt_valid held 5 cycles -> detect_add stays 1, busy=0, write_enb=0 throughout.
- fifo_empty[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1] pulses 1 cycle at cycle 30. With an address-1 packet in LOAD_DATA, the FSM returns to DECODE_ADDRESS next cycle. read_enb[1]=1 at cycle 29 -> no pulse.
- resetn=0 asserted in FIFO_FULL_STATE -> next edge detect_add=1, busy=0, soft_reset=0, write_enb=0.
